bitq_word_collector: RTL and testbench
======================================

# bitq_word_collector

Downstream stage of the serial bit queuer in the image-loading path. It triggers the queuer one 32-bit word at a time and captures each finished word into a small synchronous FIFO. The HPS drains that FIFO through a simple read port. It counts words per frame, throttles the queuer when the FIFO is full, and flags a queuer that never responds.

## Interface
Parameters:
- DEPTH_LOG2, 4, FIFO depth = 2^DEPTH_LOG2 words.
- FRAME_WORDS, 196, words per frame (28x28 pixels, 4 per word); must be ≥1.
- KICK_TIMEOUT, 4, cycles allowed after a kick pulse for busy to rise.

Ports:
- iCLK  in  1  clock. Same clock as the queuer.
- iRST  in  1  asynchronous, active-low reset.
- iStart  in  1  one-cycle pulse that begins a frame. Honoured only in IDLE.
- iQ_data  in  32  assembled word from the queuer.
- iQ_busy  in  1  queuer read-request. High while bits are being shifted in.
- oQ_start  out  1  one-cycle kick to the queuer's HPS strobe input.
- iRd_en  in  1  HPS read request.
- oRd_data  out  32  word popped by the last accepted read.
- oEmpty  out  1  FIFO empty.
- oFull  out  1  FIFO full.
- oLevel  out  DEPTH_LOG2+1  FIFO occupancy.
- oFrame_done  out  1  one-cycle pulse after the last word of a frame is stored.
- oError  out  1  sticky kick-timeout flag. Cleared only by reset or by an accepted iStart.
- oBusy  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, KICK, WAIT_HI, WAIT_LO, CAPTURE, STALL.
- IDLE:
  - iStart → clear word_cnt and oError, go to KICK.
  - Otherwise stay in IDLE.
- KICK:
  - Assert oQ_start for exactly one cycle.
  - Load timeout counter = KICK_TIMEOUT.
  - Go to WAIT_HI.
- WAIT_HI:
  - iQ_busy sampled high → WAIT_LO.
  - Otherwise decrement the timeout counter. At 0: set oError and go to IDLE. No frame_done is issued.
- WAIT_LO:
  - Wait with no timeout.
  - iQ_busy sampled low → CAPTURE.
- CAPTURE:
  - Write iQ_data to mem[wr_ptr] and advance wr_ptr.
  - If word_cnt == FRAME_WORDS-1: pulse oFrame_done and go to IDLE.
  - Else increment word_cnt. Then:
    - If the FIFO will be full after this cycle's write and read → STALL.
    - Otherwise → KICK.
- STALL:
  - Leave for KICK on the first cycle oFull is low.
- FIFO:
  - Pointers are DEPTH_LOG2 bits wide and wrap modulo depth.
  - Level is DEPTH_LOG2+1 bits wide.
  - A read is accepted when iRd_en && !oEmpty. iRd_en while empty is ignored: no pointer or data change.
  - A write happens only in CAPTURE. The FSM guarantees the FIFO is never full there, so writes are never dropped.
  - Write and accepted read in the same cycle → level unchanged, both pointers advance.
  - oEmpty = (level==0), oFull = (level==2^DEPTH_LOG2), both combinational from level.
- Reset mid-operation returns all state to reset values. FIFO contents are discarded by clearing pointers and level. Memory array contents are don't-care.

## Timing
- Reset values:
  - oQ_start=0, oRd_data=0, oEmpty=1, oFull=0, oLevel=0, oFrame_done=0, oError=0, oBusy=0.
  - FSM=IDLE, word_cnt=0.
- iStart sampled at edge t → oQ_start high during cycle t+1 only.
- The queuer raises busy one edge after it samples the kick. WAIT_HI normally sees busy at the 2nd edge after KICK.
- The queuer drops busy after its last negedge bit write, so iQ_data is stable when busy is first sampled low.
- CAPTURE occurs on the cycle after busy is sampled low. The write is visible in oLevel the cycle after CAPTURE.
- Per-word period with no stall = 1 (KICK) + WAIT_HI + queuer busy time (~64) + 1 (WAIT_LO exit) + 1 (CAPTURE).
- Read latency is 1:
  - iRd_en accepted at edge t → oRd_data = head word after edge t.
  - oLevel decrements after edge t.
  - oRd_data holds its value until the next accepted read.
- oFrame_done is high exactly one cycle, in the cycle following CAPTURE of word FRAME_WORDS-1.
- oBusy drops in that same cycle.
- iStart while oBusy=1 has no effect.

## Test plan
- Reset then single frame:
  - Setup: FRAME_WORDS=3, bench queuer model returns 0xA5A5_0001, 0xA5A5_0002, 0xA5A5_0003. iStart pulse.
  - Expect: 3 oQ_start pulses, oLevel=3, one oFrame_done pulse, then reads return the words in order and oEmpty=1.
- Full throttle:
  - Setup: DEPTH_LOG2=2, FRAME_WORDS=6, no reads.
  - Expect: after 4 words oFull=1, FSM in STALL, no oQ_start.
  - Then one read returns word 0 and the next cycle oQ_start pulses. Draining all reads gives words 1..5 in order.
- Simultaneous read/write:
  - Setup: level=2, iRd_en asserted on the CAPTURE cycle.
  - Expect: oLevel stays 2, oRd_data = oldest word, no word lost.
- Kick timeout:
  - Setup: iQ_busy tied low, iStart.
  - Expect: one oQ_start, then after KICK_TIMEOUT=4 cycles oError=1, oBusy=0, no oFrame_done.
  - Then a new iStart clears oError.
- Read while empty:
  - Setup: iRd_en held high with level=0 for 5 cycles.
  - Expect: oRd_data unchanged, oLevel=0, pointers unchanged.
  - Then a write of 0x1234_5678 followed by a read returns 0x1234_5678.
- Reset mid-frame:
  - Setup: assert iRST low during WAIT_LO of word 2.
  - Expect: all outputs at reset values immediately (asynchronous).
  - After release, iStart starts a fresh frame with word_cnt=0 and oLevel=0.

Source files
------------

// File: rtl/bitq_word_collector.sv
`default_nettype none
// ============================================================================
//  Module   : bitq_word_collector
//  Purpose  : Downstream stage of the serial bit queuer. It kicks the queuer
//             one 32-bit word at a time and captures each finished word into
//             a small synchronous FIFO, which the HPS drains through a simple
//             read port. It counts words per frame, holds off the queuer while
//             the FIFO is full, and flags a queuer that never answers a kick.
//  Ports    : iCLK, iRST (async, active-low)
//             iStart       - frame start pulse, honoured only while idle
//             iQ_data      - assembled word from the queuer
//             iQ_busy      - queuer busy (high while bits shift in)
//             oQ_start     - one-cycle kick to the queuer
//             iRd_en       - HPS read request
//             oRd_data     - word popped by the last accepted read
//             oEmpty/oFull - FIFO flags
//             oLevel       - FIFO occupancy
//             oFrame_done  - pulse after the last word of a frame is stored
//             oError       - sticky kick-timeout flag
//             oBusy        - FSM not idle
//  Revision : 1.0 - initial release
// ============================================================================
module bitq_word_collector #(
  parameter int DEPTH_LOG2   = 4,
  parameter int FRAME_WORDS  = 196,
  parameter int KICK_TIMEOUT = 4
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iStart,
  input  logic [31:0]           iQ_data,
  input  logic                  iQ_busy,
  output logic                  oQ_start,
  input  logic                  iRd_en,
  output logic [31:0]           oRd_data,
  output logic                  oEmpty,
  output logic                  oFull,
  output logic [DEPTH_LOG2:0]   oLevel,
  output logic                  oFrame_done,
  output logic                  oError,
  output logic                  oBusy
);

  localparam int c_DEPTH = 1 << DEPTH_LOG2;
  localparam int c_CNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int c_TMO_W = (KICK_TIMEOUT > 1) ? $clog2(KICK_TIMEOUT + 1) : 1;

  localparam logic [c_CNT_W-1:0]    c_LAST_WORD  = c_CNT_W'(FRAME_WORDS - 1);
  localparam logic [c_CNT_W-1:0]    c_CNT_ONE    = c_CNT_W'(1);
  localparam logic [c_TMO_W-1:0]    c_TMO_LOAD   = c_TMO_W'(KICK_TIMEOUT);
  localparam logic [c_TMO_W-1:0]    c_TMO_ONE    = c_TMO_W'(1);
  localparam logic [DEPTH_LOG2:0]   c_LEVEL_FULL = (DEPTH_LOG2 + 1)'(c_DEPTH);
  localparam logic [DEPTH_LOG2:0]   c_LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE    = DEPTH_LOG2'(1);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_KICK    = 3'd1;
  localparam logic [2:0] c_WAIT_HI = 3'd2;
  localparam logic [2:0] c_WAIT_LO = 3'd3;
  localparam logic [2:0] c_CAPTURE = 3'd4;
  localparam logic [2:0] c_STALL   = 3'd5;

  logic [2:0]            r_state;
  logic [c_CNT_W-1:0]    r_wordCnt;
  logic [c_TMO_W-1:0]    r_tmo;
  logic                  r_error;
  logic                  r_frameDone;

  logic [31:0]           r_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wrPtr;
  logic [DEPTH_LOG2-1:0] r_rdPtr;
  logic [DEPTH_LOG2:0]   r_level;
  logic [31:0]           r_rdData;

  logic                  w_wrEn;
  logic                  w_rdAccept;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_fullAfter;
  logic [DEPTH_LOG2:0]   w_levelNext;

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == c_LEVEL_FULL);
  assign w_wrEn     = (r_state == c_CAPTURE);
  assign w_rdAccept = iRd_en && !w_empty;

  always_comb begin
    w_levelNext = r_level;
    if (w_wrEn && !w_rdAccept) begin
      w_levelNext = r_level + c_LEVEL_ONE;
    end else if (!w_wrEn && w_rdAccept) begin
      w_levelNext = r_level - c_LEVEL_ONE;
    end
  end

  // Occupancy after this cycle's write and read; decides STALL vs KICK.
  assign w_fullAfter = (w_levelNext == c_LEVEL_FULL);

  // Storage is deliberately unreset: clearing pointers and level discards it.
  always_ff @(posedge iCLK) begin
    if (w_wrEn) begin
      r_mem[r_wrPtr] <= iQ_data;
    end
  end

  // A concurrent read never targets the slot being written: a read needs
  // level>0 and a write needs level<depth, so the pointers differ.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      r_level  <= '0;
      r_rdData <= '0;
    end else begin
      if (w_wrEn) begin
        r_wrPtr <= r_wrPtr + c_PTR_ONE;
      end
      if (w_rdAccept) begin
        r_rdData <= r_mem[r_rdPtr];
        r_rdPtr  <= r_rdPtr + c_PTR_ONE;
      end
      r_level <= w_levelNext;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state     <= c_IDLE;
      r_wordCnt   <= '0;
      r_tmo       <= '0;
      r_error     <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (iStart) begin
            r_wordCnt <= '0;
            r_error   <= 1'b0;
            r_state   <= c_KICK;
          end
        end
        c_KICK: begin
          r_tmo   <= c_TMO_LOAD;
          r_state <= c_WAIT_HI;
        end
        c_WAIT_HI: begin
          if (iQ_busy) begin
            r_state <= c_WAIT_LO;
          end else if (r_tmo == c_TMO_ONE || r_tmo == '0) begin
            // Counter reaches zero on this decrement: give up on the queuer.
            r_tmo   <= '0;
            r_error <= 1'b1;
            r_state <= c_IDLE;
          end else begin
            r_tmo <= r_tmo - c_TMO_ONE;
          end
        end
        c_WAIT_LO: begin
          if (!iQ_busy) begin
            r_state <= c_CAPTURE;
          end
        end
        c_CAPTURE: begin
          if (r_wordCnt == c_LAST_WORD) begin
            r_frameDone <= 1'b1;
            r_state     <= c_IDLE;
          end else begin
            r_wordCnt <= r_wordCnt + c_CNT_ONE;
            r_state   <= w_fullAfter ? c_STALL : c_KICK;
          end
        end
        c_STALL: begin
          if (!w_full) begin
            r_state <= c_KICK;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign oQ_start    = (r_state == c_KICK);
  assign oRd_data    = r_rdData;
  assign oEmpty      = w_empty;
  assign oFull       = w_full;
  assign oLevel      = r_level;
  assign oFrame_done = r_frameDone;
  assign oError      = r_error;
  assign oBusy       = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bitq_word_collector.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_bitq_word_collector
//  Purpose  : Directed self-checking bench for bitq_word_collector with a
//             small behavioural queuer that answers each kick.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bitq_word_collector;

  localparam int DEPTH_LOG2   = 2;
  localparam int FRAME_WORDS  = 6;
  localparam int KICK_TIMEOUT = 4;
  localparam int BUSY_CYC     = 4;

  logic                iCLK = 1'b0;
  logic                iRST = 1'b0;
  logic                iStart = 1'b0;
  logic [31:0]         iQ_data = 32'h0;
  logic                iQ_busy = 1'b0;
  logic                iRd_en = 1'b0;
  logic                oQ_start;
  logic [31:0]         oRd_data;
  logic                oEmpty;
  logic                oFull;
  logic [DEPTH_LOG2:0] oLevel;
  logic                oFrame_done;
  logic                oError;
  logic                oBusy;

  int vecs = 0;
  int errs = 0;
  int kicks = 0;
  int dones = 0;
  int k0 = 0;
  int d0 = 0;

  logic        qEnable = 1'b1;
  logic [31:0] qWords [8];
  int          qIdx = 0;

  always #5 iCLK = ~iCLK;

  bitq_word_collector #(
    .DEPTH_LOG2  (DEPTH_LOG2),
    .FRAME_WORDS (FRAME_WORDS),
    .KICK_TIMEOUT(KICK_TIMEOUT)
  ) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iStart     (iStart),
    .iQ_data    (iQ_data),
    .iQ_busy    (iQ_busy),
    .oQ_start   (oQ_start),
    .iRd_en     (iRd_en),
    .oRd_data   (oRd_data),
    .oEmpty     (oEmpty),
    .oFull      (oFull),
    .oLevel     (oLevel),
    .oFrame_done(oFrame_done),
    .oError     (oError),
    .oBusy      (oBusy)
  );

  // Kick / frame-done pulse counters, sampled mid-cycle.
  always @(negedge iCLK) begin
    if (oQ_start) kicks++;
    if (oFrame_done) dones++;
  end

  // Queuer model: samples the kick at the next rising edge, raises busy for
  // BUSY_CYC edges, then drops busy together with the finished word.
  initial begin
    forever begin
      @(negedge iCLK);
      if (oQ_start && qEnable) begin
        @(posedge iCLK);
        #1 iQ_busy = 1'b1;
        repeat (BUSY_CYC) @(posedge iCLK);
        #1;
        iQ_data = qWords[qIdx % 8];
        qIdx++;
        iQ_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

  // Advance to just after the next falling edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge iCLK);
      #1;
    end
  endtask

  task automatic test_reset;
    iRST = 1'b0;
    cyc(2);
    vecs++; if (oQ_start !== 1'b0) begin errs++; $display("FAIL rst_qstart: got %0b want 0", oQ_start); end
    vecs++; if (oRd_data !== 32'h0) begin errs++; $display("FAIL rst_rddata: got %08h want 00000000", oRd_data); end
    vecs++; if (oEmpty !== 1'b1) begin errs++; $display("FAIL rst_empty: got %0b want 1", oEmpty); end
    vecs++; if (oFull !== 1'b0) begin errs++; $display("FAIL rst_full: got %0b want 0", oFull); end
    vecs++; if (oLevel !== 3'd0) begin errs++; $display("FAIL rst_level: got %0d want 0", oLevel); end
    vecs++; if (oFrame_done !== 1'b0) begin errs++; $display("FAIL rst_done: got %0b want 0", oFrame_done); end
    vecs++; if (oError !== 1'b0) begin errs++; $display("FAIL rst_error: got %0b want 0", oError); end
    vecs++; if (oBusy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %0b want 0", oBusy); end
    iRST = 1'b1;
    cyc(2);
  endtask

  // Fills the 4-deep FIFO, checks the stall, then exercises read/write
  // collision and the frame-done pulse before draining.
  task automatic test_full_throttle;
    int n;
    qEnable = 1'b1;
    qIdx = 0;
    for (int i = 0; i < 8; i++) qWords[i] = 32'hA5A5_0001 + i;
    k0 = kicks; d0 = dones;
    iStart = 1'b1; cyc(1); iStart = 1'b0;
    n = 0;
    while (!oFull && n < 200) begin cyc(1); n++; end
    vecs++; if (oFull !== 1'b1) begin errs++; $display("FAIL thr_full: got %0b want 1", oFull); end
    vecs++; if (oLevel !== 3'd4) begin errs++; $display("FAIL thr_level: got %0d want 4", oLevel); end
    vecs++; if (kicks - k0 !== 4) begin errs++; $display("FAIL thr_kicks: got %0d want 4", kicks - k0); end
    cyc(10);
    vecs++; if (kicks - k0 !== 4) begin errs++; $display("FAIL thr_stall_kicks: got %0d want 4", kicks - k0); end
    vecs++; if (oBusy !== 1'b1) begin errs++; $display("FAIL thr_stall_busy: got %0b want 1", oBusy); end
    iRd_en = 1'b1; cyc(1); iRd_en = 1'b0;
    vecs++; if (oRd_data !== 32'hA5A5_0001) begin errs++; $display("FAIL thr_rd0: got %08h want a5a50001", oRd_data); end
    vecs++; if (oLevel !== 3'd3) begin errs++; $display("FAIL thr_rd0_level: got %0d want 3", oLevel); end
    cyc(1);
    vecs++; if (kicks - k0 !== 5) begin errs++; $display("FAIL thr_resume_kick: got %0d want 5", kicks - k0); end
    iRd_en = 1'b1; cyc(1); iRd_en = 1'b0;
    vecs++; if (oRd_data !== 32'hA5A5_0002) begin errs++; $display("FAIL thr_rd1: got %08h want a5a50002", oRd_data); end
    vecs++; if (oLevel !== 3'd2) begin errs++; $display("FAIL thr_rd1_level: got %0d want 2", oLevel); end
    // Read lands on the CAPTURE edge of word 5.
    n = 0;
    while (iQ_busy && n < 20) begin cyc(1); n++; end
    vecs++; if (iQ_busy !== 1'b0) begin errs++; $display("FAIL thr_busy_drop: got %0b want 0", iQ_busy); end
    cyc(1);
    iRd_en = 1'b1; cyc(1); iRd_en = 1'b0;
    vecs++; if (oLevel !== 3'd2) begin errs++; $display("FAIL rw_level: got %0d want 2", oLevel); end
    vecs++; if (oRd_data !== 32'hA5A5_0003) begin errs++; $display("FAIL rw_data: got %08h want a5a50003", oRd_data); end
    n = 0;
    while (!oFrame_done && n < 40) begin cyc(1); n++; end
    vecs++; if (oFrame_done !== 1'b1) begin errs++; $display("FAIL done_pulse: got %0b want 1", oFrame_done); end
    vecs++; if (oBusy !== 1'b0) begin errs++; $display("FAIL done_busy: got %0b want 0", oBusy); end
    vecs++; if (kicks - k0 !== 6) begin errs++; $display("FAIL done_kicks: got %0d want 6", kicks - k0); end
    vecs++; if (oLevel !== 3'd3) begin errs++; $display("FAIL done_level: got %0d want 3", oLevel); end
    cyc(1);
    vecs++; if (oFrame_done !== 1'b0) begin errs++; $display("FAIL done_width: got %0b want 0", oFrame_done); end
    vecs++; if (dones - d0 !== 1) begin errs++; $display("FAIL done_count: got %0d want 1", dones - d0); end
    iRd_en = 1'b1;
    for (int i = 3; i < 6; i++) begin
      cyc(1);
      vecs++; if (oRd_data !== 32'hA5A5_0001 + i) begin errs++; $display("FAIL drain_%0d: got %08h want %08h", i, oRd_data, 32'hA5A5_0001 + i); end
    end
    iRd_en = 1'b0;
    vecs++; if (oEmpty !== 1'b1) begin errs++; $display("FAIL drain_empty: got %0b want 1", oEmpty); end
    vecs++; if (oLevel !== 3'd0) begin errs++; $display("FAIL drain_level: got %0d want 0", oLevel); end
  endtask

  task automatic test_kick_timeout;
    qEnable = 1'b0;
    k0 = kicks; d0 = dones;
    iStart = 1'b1; cyc(1); iStart = 1'b0;
    vecs++; if (oQ_start !== 1'b1) begin errs++; $display("FAIL to_kick: got %0b want 1", oQ_start); end
    cyc(1);
    vecs++; if (oQ_start !== 1'b0) begin errs++; $display("FAIL to_kick_width: got %0b want 0", oQ_start); end
    cyc(3);
    vecs++; if (oError !== 1'b0) begin errs++; $display("FAIL to_early: got %0b want 0", oError); end
    vecs++; if (oBusy !== 1'b1) begin errs++; $display("FAIL to_wait_busy: got %0b want 1", oBusy); end
    cyc(1);
    vecs++; if (oError !== 1'b1) begin errs++; $display("FAIL to_error: got %0b want 1", oError); end
    vecs++; if (oBusy !== 1'b0) begin errs++; $display("FAIL to_idle: got %0b want 0", oBusy); end
    vecs++; if (kicks - k0 !== 1) begin errs++; $display("FAIL to_kicks: got %0d want 1", kicks - k0); end
    vecs++; if (dones - d0 !== 0) begin errs++; $display("FAIL to_no_done: got %0d want 0", dones - d0); end
    iStart = 1'b1; cyc(1); iStart = 1'b0;
    vecs++; if (oError !== 1'b0) begin errs++; $display("FAIL to_clear: got %0b want 0", oError); end
    cyc(8);
    vecs++; if (oError !== 1'b1) begin errs++; $display("FAIL to_error2: got %0b want 1", oError); end
    qEnable = 1'b1;
  endtask

  task automatic test_read_empty;
    int n;
    iRd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      vecs++; if (oRd_data !== 32'hA5A5_0006) begin errs++; $display("FAIL empty_rd_%0d: got %08h want a5a50006", i, oRd_data); end
      vecs++; if (oLevel !== 3'd0) begin errs++; $display("FAIL empty_level_%0d: got %0d want 0", i, oLevel); end
    end
    iRd_en = 1'b0;
    qIdx = 0;
    qWords[0] = 32'h1234_5678;
    for (int i = 1; i < 8; i++) qWords[i] = 32'hBEEF_0000 + i;
    iStart = 1'b1; cyc(1); iStart = 1'b0;
    n = 0;
    while (oLevel != 3'd1 && n < 40) begin cyc(1); n++; end
    vecs++; if (oLevel !== 3'd1) begin errs++; $display("FAIL empty_wr_level: got %0d want 1", oLevel); end
    iRd_en = 1'b1; cyc(1); iRd_en = 1'b0;
    vecs++; if (oRd_data !== 32'h1234_5678) begin errs++; $display("FAIL empty_wr_rd: got %08h want 12345678", oRd_data); end
    vecs++; if (oLevel !== 3'd0) begin errs++; $display("FAIL empty_wr_rd_level: got %0d want 0", oLevel); end
  endtask

  // Continues the frame started above: reset during WAIT_LO of word 2.
  task automatic test_reset_midframe;
    int n;
    int rdIdx;
    bit pend;
    n = 0;
    while (!iQ_busy && n < 20) begin cyc(1); n++; end
    cyc(1);
    vecs++; if (oBusy !== 1'b1) begin errs++; $display("FAIL mid_pre_busy: got %0b want 1", oBusy); end
    iRST = 1'b0;
    #1;
    vecs++; if (oBusy !== 1'b0) begin errs++; $display("FAIL mid_busy: got %0b want 0", oBusy); end
    vecs++; if (oRd_data !== 32'h0) begin errs++; $display("FAIL mid_rddata: got %08h want 00000000", oRd_data); end
    vecs++; if (oEmpty !== 1'b1 || oFull !== 1'b0 || oLevel !== 3'd0) begin errs++; $display("FAIL mid_fifo: got e=%0b f=%0b l=%0d want e=1 f=0 l=0", oEmpty, oFull, oLevel); end
    vecs++; if (oQ_start !== 1'b0 || oFrame_done !== 1'b0 || oError !== 1'b0) begin errs++; $display("FAIL mid_flags: got q=%0b d=%0b e=%0b want 0 0 0", oQ_start, oFrame_done, oError); end
    n = 0;
    while (iQ_busy && n < 20) begin cyc(1); n++; end
    cyc(2);
    iRST = 1'b1;
    cyc(1);
    vecs++; if (oLevel !== 3'd0) begin errs++; $display("FAIL mid_rel_level: got %0d want 0", oLevel); end
    qIdx = 0;
    for (int i = 0; i < 8; i++) qWords[i] = 32'hC0DE_0000 + i;
    k0 = kicks; d0 = dones;
    rdIdx = 0; pend = 1'b0;
    iStart = 1'b1; cyc(1); iStart = 1'b0;
    for (int i = 0; i < 400; i++) begin
      cyc(1);
      if (pend) begin
        vecs++; if (oRd_data !== 32'hC0DE_0000 + rdIdx) begin errs++; $display("FAIL fresh_rd_%0d: got %08h want %08h", rdIdx, oRd_data, 32'hC0DE_0000 + rdIdx); end
        rdIdx++;
        pend = 1'b0;
      end
      if (dones != d0 && oEmpty) begin iRd_en = 1'b0; break; end
      iRd_en = !oEmpty;
      pend = !oEmpty;
    end
    iRd_en = 1'b0;
    vecs++; if (rdIdx !== 6) begin errs++; $display("FAIL fresh_words: got %0d want 6", rdIdx); end
    vecs++; if (kicks - k0 !== 6) begin errs++; $display("FAIL fresh_kicks: got %0d want 6", kicks - k0); end
    vecs++; if (dones - d0 !== 1) begin errs++; $display("FAIL fresh_done: got %0d want 1", dones - d0); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) qWords[i] = 32'h0;
    test_reset;
    test_full_throttle;
    test_kick_timeout;
    test_read_empty;
    test_reset_midframe;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
